alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-port arbiter and sequencer for the single shared 64-bit integer ALU. Requester 0 is the execute stage and requester 1 is the branch/address-generation path. Each requester has a valid/ready request channel and a single-entry response buffer. The block selects one requester per cycle, drives the ALU, and captures the result into that requester's response buffer. RV64 shift-amount masking and illegal-opcode detection are done here, so the ALU stays purely combinational.

## Interface
- XLEN, 64, operand/result width
- TAG_W, 5, width of requester tag (e.g. destination register index)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- reqN_valid  in  1  request N (N = 0, 1) presents an operation
- reqN_ready  out  1  request N accepted this cycle
- reqN_op  in  4  ALU opcode
- reqN_a, reqN_b  in  XLEN  operands
- reqN_tag  in  TAG_W  opaque tag, returned with result
- rspN_valid  out  1  response buffer N holds a result
- rspN_ready  in  1  consumer N takes the result this cycle
- rspN_result  out  XLEN  captured ALU result
- rspN_tag  out  TAG_W  tag of the captured request
- rspN_err  out  1  captured request used an illegal opcode
- alu_a, alu_b  out  XLEN  shared ALU operands
- alu_opcodes  out  4  shared ALU opcode
- alu_result  in  XLEN  shared ALU combinational result

## Operation
- Legal opcodes:
  - 0000 add, 0001 sub, 0010 sll, 0100 slt, 0110 sltu
  - 1000 xor, 1010 srl, 1011 sra, 1100 or, 1110 and
  - All other values are illegal.
- free_N = !rspN_valid || rspN_ready. A buffer draining in the same cycle counts as free.
- elig_N = reqN_valid && free_N.
- Grant:
  - Only one requester eligible: it wins.
  - Both eligible: the requester not granted most recently wins.
  - Round-robin pointer `last` resets to 1, so requester 0 wins the first tie.
  - `last` updates only on a grant.
- reqN_ready = grant_N. Ready depends on reqN_valid and on free_N. The other requester sees ready = 0 that cycle.
- ALU drive is combinational from the winner:
  - alu_opcodes = reqW_op.
  - alu_a = reqW_a.
  - alu_b = reqW_b, except for opcodes 0010/1010/1011, where alu_b = {58'b0, reqW_b[5:0]}.
  - With no grant: alu_a = alu_b = 0, alu_opcodes = 0000.
- Capture at the clock edge with grant_N:
  - rspN_valid ← 1.
  - rspN_tag ← reqN_tag.
  - rspN_err ← illegal(reqN_op).
  - rspN_result ← 0 if illegal, else alu_result.
- Drain: rspN_valid && rspN_ready with no new grant_N → rspN_valid ← 0. result/tag/err keep their last values.
- While rspN_valid && !rspN_ready, rspN_result, rspN_tag and rspN_err stay stable.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - rspN_valid = 0, rspN_result = 0, rspN_tag = 0, rspN_err = 0.
  - last = 1.
  - Combinational outputs go to their no-grant values, since reqN_valid is low in reset.
- Latency: a request accepted at edge k has rspN_valid = 1 from edge k until it is consumed.
- Throughput:
  - Aggregate is 1 operation per cycle.
  - A single requester sustains 1 per cycle while rspN_ready is held high, because drain and accept happen in the same cycle.
- Simultaneous drain and accept on port N: the buffer is overwritten with the new result and rspN_valid stays 1. No bubble.
- Buffer full with consumer stalled: reqN_ready = 0, the other port may be granted, and no request is lost.
- Reset mid-operation: buffered results are discarded and an un-acknowledged request is not captured.
- No combinational path from alu_result to any ready signal.

## Test plan
- Single op, rsp0_ready = 1:
  - Stimulus: req0 add, a = 5, b = 7, tag = 3.
  - Required: req0_ready = 1 that cycle; next cycle rsp0_valid = 1, rsp0_result = 12, rsp0_tag = 3, rsp0_err = 0.
- Tie arbitration:
  - Stimulus: both valid continuously for 4 cycles, both rsp_ready = 1.
  - Required: grants go 0, 1, 0, 1, and each response matches its own operands.
- Backpressure:
  - Stimulus: rsp1_ready = 0 after req1 xor, a = 0xF0, b = 0xFF is accepted.
  - Required: req1_ready stays 0 while req0 keeps being granted; rsp1_result holds 0x0F stable.
  - Then raise rsp1_ready: req1_ready = 1 in the same cycle.
- Shift masking:
  - Stimulus: req0 sll, a = 1, b = 0x41.
  - Required: alu_b = 1 and rsp0_result = 2.
  - Same check with sra, a = 0x8000_0000_0000_0000, b = 0x7F: alu_b = 0x3F.
- Illegal opcode:
  - Stimulus: req1 op = 0011.
  - Required: accepted; rsp1_err = 1 and rsp1_result = 0.
- Async reset:
  - Stimulus: assert rst mid-cycle while both response buffers are full.
  - Required: rspN_valid drops to 0 immediately; after release, a tie grants requester 0 first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter sharing one combinational 64-bit ALU between two requesters
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   i_reqN_valid/o_reqN_ready request handshake for requester N (0 = execute, 1 = branch/AGU)
//   i_reqN_op/_a/_b/_tag      opcode, operands and opaque tag of request N
//   o_rspN_valid/i_rspN_ready single-entry response buffer handshake for requester N
//   o_rspN_result/_tag/_err   captured result, returned tag, illegal-opcode flag
//   o_alu_a/_b/_opcodes       operands and opcode driven to the shared ALU
//   i_alu_result              combinational result from the shared ALU
module alu_share_arbiter #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [3:0]       i_req0_op,
    input  logic [XLEN-1:0]  i_req0_a,
    input  logic [XLEN-1:0]  i_req0_b,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [3:0]       i_req1_op,
    input  logic [XLEN-1:0]  i_req1_a,
    input  logic [XLEN-1:0]  i_req1_b,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [XLEN-1:0]  o_rsp0_result,
    output logic [TAG_W-1:0] o_rsp0_tag,
    output logic             o_rsp0_err,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [XLEN-1:0]  o_rsp1_result,
    output logic [TAG_W-1:0] o_rsp1_tag,
    output logic             o_rsp1_err,
    output logic [XLEN-1:0]  o_alu_a,
    output logic [XLEN-1:0]  o_alu_b,
    output logic [3:0]       o_alu_opcodes,
    input  logic [XLEN-1:0]  i_alu_result
);
    logic             w_free0, w_free1, w_elig0, w_elig1, w_gnt0, w_gnt1, w_shift;
    logic [XLEN-1:0]  w_b;
    logic             r_last;
    logic             r_rsp0_valid, r_rsp1_valid, r_rsp0_err, r_rsp1_err;
    logic [XLEN-1:0]  r_rsp0_result, r_rsp1_result;
    logic [TAG_W-1:0] r_rsp0_tag, r_rsp1_tag;

    function automatic logic illegal(input logic [3:0] op);
        return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
                            4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110});
    endfunction

    // A buffer being drained this cycle can accept a new result in the same cycle
    assign w_free0 = !r_rsp0_valid || i_rsp0_ready;
    assign w_free1 = !r_rsp1_valid || i_rsp1_ready;
    assign w_elig0 = i_req0_valid && w_free0;
    assign w_elig1 = i_req1_valid && w_free1;
    // r_last = 1 means requester 1 won most recently, so requester 0 takes the tie
    assign w_gnt0  = w_elig0 && (!w_elig1 || r_last);
    assign w_gnt1  = w_elig1 && (!w_elig0 || !r_last);

    assign o_req0_ready  = w_gnt0;
    assign o_req1_ready  = w_gnt1;
    assign o_alu_opcodes = w_gnt1 ? i_req1_op : w_gnt0 ? i_req0_op : 4'b0000;
    assign o_alu_a       = w_gnt1 ? i_req1_a : w_gnt0 ? i_req0_a : '0;
    assign w_b           = w_gnt1 ? i_req1_b : w_gnt0 ? i_req0_b : '0;
    // RV64 shifts use only the low six bits of the shift amount
    assign w_shift       = o_alu_opcodes inside {4'b0010, 4'b1010, 4'b1011};
    assign o_alu_b       = w_shift ? {{(XLEN-6){1'b0}}, w_b[5:0]} : w_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last        <= 1'b1;
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp0_tag    <= '0;
            r_rsp0_err    <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= '0;
            r_rsp1_tag    <= '0;
            r_rsp1_err    <= 1'b0;
        end else begin
            if (w_gnt0 || w_gnt1)
                r_last <= w_gnt1;
            if (w_gnt0) begin
                r_rsp0_valid  <= 1'b1;
                r_rsp0_tag    <= i_req0_tag;
                r_rsp0_err    <= illegal(i_req0_op);
                r_rsp0_result <= illegal(i_req0_op) ? '0 : i_alu_result;
            end else if (i_rsp0_ready) begin
                r_rsp0_valid  <= 1'b0;
            end
            if (w_gnt1) begin
                r_rsp1_valid  <= 1'b1;
                r_rsp1_tag    <= i_req1_tag;
                r_rsp1_err    <= illegal(i_req1_op);
                r_rsp1_result <= illegal(i_req1_op) ? '0 : i_alu_result;
            end else if (i_rsp1_ready) begin
                r_rsp1_valid  <= 1'b0;
            end
        end
    end

    assign o_rsp0_valid  = r_rsp0_valid;
    assign o_rsp0_result = r_rsp0_result;
    assign o_rsp0_tag    = r_rsp0_tag;
    assign o_rsp0_err    = r_rsp0_err;
    assign o_rsp1_valid  = r_rsp1_valid;
    assign o_rsp1_result = r_rsp1_result;
    assign o_rsp1_tag    = r_rsp1_tag;
    assign o_rsp1_err    = r_rsp1_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with a response scoreboard and an external ALU model
module tb_alu_share_arbiter;
    localparam int XLEN = 64, TAG_W = 5;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_SLL = 4'b0010, OP_SLT = 4'b0100,
                           OP_SLTU = 4'b0110, OP_XOR = 4'b1000, OP_SRL = 4'b1010, OP_SRA = 4'b1011,
                           OP_OR = 4'b1100, OP_AND = 4'b1110;

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic i_req0_valid = 0, i_req1_valid = 0, i_rsp0_ready = 0, i_rsp1_ready = 0;
    logic [3:0] i_req0_op = 0, i_req1_op = 0;
    logic [XLEN-1:0] i_req0_a = 0, i_req0_b = 0, i_req1_a = 0, i_req1_b = 0;
    logic [TAG_W-1:0] i_req0_tag = 0, i_req1_tag = 0;
    logic o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp0_err, o_rsp1_err;
    logic [XLEN-1:0] o_rsp0_result, o_rsp1_result, o_alu_a, o_alu_b, i_alu_result;
    logic [TAG_W-1:0] o_rsp0_tag, o_rsp1_tag;
    logic [3:0] o_alu_opcodes;

    rsp_t q0[$], q1[$];
    int n_tests = 0, n_fail = 0, i0 = 0, i1 = 0;

    alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_tag(i_req0_tag),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_tag(i_req1_tag),
        .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready), .o_rsp0_result(o_rsp0_result),
        .o_rsp0_tag(o_rsp0_tag), .o_rsp0_err(o_rsp0_err),
        .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready), .o_rsp1_result(o_rsp1_result),
        .o_rsp1_tag(o_rsp1_tag), .o_rsp1_err(o_rsp1_err),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_opcodes(o_alu_opcodes),
        .i_alu_result(i_alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU; shifts use the full operand so unmasked shift amounts show up in results
    always_comb begin
        case (o_alu_opcodes)
            OP_ADD:  i_alu_result = o_alu_a + o_alu_b;
            OP_SUB:  i_alu_result = o_alu_a - o_alu_b;
            OP_SLL:  i_alu_result = o_alu_a << o_alu_b;
            OP_SLT:  i_alu_result = {63'b0, $signed(o_alu_a) < $signed(o_alu_b)};
            OP_SLTU: i_alu_result = {63'b0, o_alu_a < o_alu_b};
            OP_XOR:  i_alu_result = o_alu_a ^ o_alu_b;
            OP_SRL:  i_alu_result = o_alu_a >> o_alu_b;
            OP_SRA:  i_alu_result = $signed(o_alu_a) >>> o_alu_b;
            OP_OR:   i_alu_result = o_alu_a | o_alu_b;
            OP_AND:  i_alu_result = o_alu_a & o_alu_b;
            default: i_alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    end

    function automatic rsp_t mk(input logic [XLEN-1:0] res, input logic [TAG_W-1:0] tag, input logic err);
        mk.res = res;
        mk.tag = tag;
        mk.err = err;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
        i_req0_valid = v; i_req0_op = op; i_req0_a = a; i_req0_b = b; i_req0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
        i_req1_valid = v; i_req1_op = op; i_req1_a = a; i_req1_b = b; i_req1_tag = t;
    endtask

    // Monitor: a response is consumed at the next edge whenever valid and ready are both high
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && o_rsp0_valid && i_rsp0_ready) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp0_unexpected: got result 0x%h tag %0d, expected no response", o_rsp0_result, o_rsp0_tag);
            end else begin
                e = q0.pop_front();
                chk("rsp0_result", o_rsp0_result, e.res);
                chk("rsp0_tag", 64'(o_rsp0_tag), 64'(e.tag));
                chk("rsp0_err", 64'(o_rsp0_err), 64'(e.err));
            end
        end
        if (!rst && o_rsp1_valid && i_rsp1_ready) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp1_unexpected: got result 0x%h tag %0d, expected no response", o_rsp1_result, o_rsp1_tag);
            end else begin
                e = q1.pop_front();
                chk("rsp1_result", o_rsp1_result, e.res);
                chk("rsp1_tag", 64'(o_rsp1_tag), 64'(e.tag));
                chk("rsp1_err", 64'(o_rsp1_err), 64'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_rsp0_valid", 64'(o_rsp0_valid), 0);
        chk("reset_rsp1_valid", 64'(o_rsp1_valid), 0);
        chk("reset_rsp0_result", o_rsp0_result, 0);
        chk("reset_rsp1_tag", 64'(o_rsp1_tag), 0);
        chk("reset_rsp1_err", 64'(o_rsp1_err), 0);
        chk("reset_alu_a", o_alu_a, 0);
        chk("reset_alu_op", 64'(o_alu_opcodes), 0);

        // Tie arbitration: both requesters keep presenting work, grants alternate 0,1,0,1
        i_rsp0_ready = 1; i_rsp1_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            set0(1, i0 == 0 ? OP_ADD : OP_SUB, i0 == 0 ? 64'd10 : 64'd100, i0 == 0 ? 64'd20 : 64'd1, i0 == 0 ? 5'd1 : 5'd2);
            set1(1, i1 == 0 ? OP_OR : OP_AND, i1 == 0 ? 64'hF0 : 64'hFF, i1 == 0 ? 64'h0F : 64'h3C, i1 == 0 ? 5'd4 : 5'd5);
            #1;
            chk("tie_ready0", 64'(o_req0_ready), 64'(c % 2 == 0));
            chk("tie_ready1", 64'(o_req1_ready), 64'(c % 2 == 1));
            if (o_req0_ready) begin q0.push_back(i0 == 0 ? mk(64'd30, 5'd1, 0) : mk(64'd99, 5'd2, 0)); i0++; end
            if (o_req1_ready) begin q1.push_back(i1 == 0 ? mk(64'hFF, 5'd4, 0) : mk(64'h3C, 5'd5, 0)); i1++; end
        end
        @(posedge clk); #1 set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);

        // Single add on port 0
        @(posedge clk); #1 set0(1, OP_ADD, 5, 7, 3);
        #1 chk("single_ready0", 64'(o_req0_ready), 1);
        if (o_req0_ready) q0.push_back(mk(64'd12, 5'd3, 0));
        @(posedge clk); #1 set0(0, 0, 0, 0, 0);
        #1 chk("single_rsp0_valid", 64'(o_rsp0_valid), 1);
        chk("single_rsp0_result", o_rsp0_result, 12);

        // Backpressure on port 1 while port 0 keeps flowing
        i_rsp1_ready = 0;
        @(posedge clk); #1 set1(1, OP_XOR, 64'hF0, 64'hFF, 7);
        #1 chk("bp_accept_ready1", 64'(o_req1_ready), 1);
        if (o_req1_ready) q1.push_back(mk(64'h0F, 5'd7, 0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            set1(1, OP_ADD, 1, 1, 8);
            set0(1, OP_ADD, 64'(c), 1, 5'(10 + c));
            #1;
            chk("bp_ready1_low", 64'(o_req1_ready), 0);
            chk("bp_ready0_high", 64'(o_req0_ready), 1);
            chk("bp_rsp1_valid", 64'(o_rsp1_valid), 1);
            chk("bp_rsp1_stable", o_rsp1_result, 64'h0F);
            if (o_req0_ready) q0.push_back(mk(64'(c + 1), 5'(10 + c), 0));
        end
        @(posedge clk); #1 set0(0, 0, 0, 0, 0); i_rsp1_ready = 1;
        #1 chk("bp_release_ready1", 64'(o_req1_ready), 1);
        if (o_req1_ready) q1.push_back(mk(64'd2, 5'd8, 0));
        @(posedge clk); #1 set1(0, 0, 0, 0, 0);

        // Shift-amount masking
        @(posedge clk); #1 set0(1, OP_SLL, 1, 64'h41, 11);
        #1 chk("sll_alu_b", o_alu_b, 1);
        chk("sll_ready0", 64'(o_req0_ready), 1);
        if (o_req0_ready) q0.push_back(mk(64'd2, 5'd11, 0));
        @(posedge clk); #1 set0(1, OP_SRA, 64'h8000_0000_0000_0000, 64'h7F, 12);
        #1 chk("sra_alu_b", o_alu_b, 64'h3F);
        chk("sra_alu_a", o_alu_a, 64'h8000_0000_0000_0000);
        if (o_req0_ready) q0.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 0));
        @(posedge clk); #1 set0(0, 0, 0, 0, 0);

        // Illegal opcode on port 1
        @(posedge clk); #1 set1(1, 4'b0011, 5, 6, 9);
        #1 chk("illegal_ready1", 64'(o_req1_ready), 1);
        if (o_req1_ready) q1.push_back(mk(64'd0, 5'd9, 1));
        @(posedge clk); #1 set1(0, 0, 0, 0, 0);
        #1 chk("illegal_rsp1_err", 64'(o_rsp1_err), 1);

        // Fill both buffers with consumers stalled, then reset asynchronously
        @(posedge clk); #1 i_rsp0_ready = 0; i_rsp1_ready = 0;
        set0(1, OP_ADD, 2, 2, 13); set1(1, OP_ADD, 3, 3, 14);
        @(posedge clk);
        @(posedge clk); #1 set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        #1 chk("prerst_rsp0_valid", 64'(o_rsp0_valid), 1);
        chk("prerst_rsp1_valid", 64'(o_rsp1_valid), 1);
        #1 rst = 1;
        #1 chk("rst_rsp0_valid", 64'(o_rsp0_valid), 0);
        chk("rst_rsp1_valid", 64'(o_rsp1_valid), 0);
        chk("rst_rsp0_result", o_rsp0_result, 0);
        q0.delete(); q1.delete();
        @(posedge clk); #1 rst = 0; i_rsp0_ready = 1; i_rsp1_ready = 1;
        set0(1, OP_ADD, 7, 8, 15); set1(1, OP_SUB, 9, 4, 16);
        #1 chk("postrst_ready0", 64'(o_req0_ready), 1);
        chk("postrst_ready1", 64'(o_req1_ready), 0);
        if (o_req0_ready) q0.push_back(mk(64'd15, 5'd15, 0));
        @(posedge clk); #1 set0(0, 0, 0, 0, 0);
        #1 chk("postrst_second_ready1", 64'(o_req1_ready), 1);
        if (o_req1_ready) q1.push_back(mk(64'd5, 5'd16, 0));
        @(posedge clk); #1 set1(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1 chk("q0_drained", 64'(q0.size()), 0);
        chk("q1_drained", 64'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
